// File: rtl/axis_parity_checker.sv
// Packet parity checker on AXI-Stream: folds every bit of each packet into one
// parity bit and emits a single-beat result {count, error, parity} per packet.
module axis_parity_checker #(
  parameter int DATA_WIDTH = 8,
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic                  in_clock,
  input  logic                  in_reset,
  input  logic                  axis_s_tvalid,
  input  logic [DATA_WIDTH-1:0] axis_s_tdata,
  output logic                  axis_s_tready,
  input  logic                  axis_s_tlast,
  output logic                  axis_m_tvalid,
  output logic [DATA_WIDTH-1:0] axis_m_tdata,
  input  logic                  axis_m_tready,
  output logic                  axis_m_tlast
);

  localparam int CW = DATA_WIDTH - 2;

  typedef enum logic {ACCUM, RESULT} state_t;

  state_t          state, state_nxt;
  logic            rst_q;
  logic            acc;
  logic [CW-1:0]   cnt, cnt_sat;
  logic            s_fire, m_fire, par;

  // Ready is held low through the cycle after reset so it only rises on the
  // first edge after in_reset falls; it never depends on axis_m_tready.
  assign axis_s_tready = (state == ACCUM) && !rst_q;
  assign axis_m_tvalid = (state == RESULT);
  assign axis_m_tlast  = (state == RESULT);

  assign s_fire  = axis_s_tvalid && axis_s_tready;
  assign m_fire  = axis_m_tvalid && axis_m_tready;
  assign par     = acc ^ (^axis_s_tdata);
  assign cnt_sat = (cnt == {CW{1'b1}}) ? cnt : cnt + CW'(1);

  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:  if (s_fire && axis_s_tlast) state_nxt = RESULT;
      RESULT: if (m_fire)                 state_nxt = ACCUM;
      default:                            state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      state        <= ACCUM;
      rst_q        <= 1'b1;
      acc          <= 1'b0;
      cnt          <= '0;
      axis_m_tdata <= '0;
    end else begin
      state <= state_nxt;
      rst_q <= 1'b0;
      if (s_fire) begin
        if (axis_s_tlast) begin
          axis_m_tdata <= {cnt_sat, par ^ ODD_PARITY, par};
          acc          <= 1'b0;
          cnt          <= '0;
        end else begin
          acc <= par;
          cnt <= cnt_sat;
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_parity_checker.sv
// Directed bench: three checker configurations share one stimulus stream and
// are compared against hand-computed result words.
module tb_axis_parity_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_tvalid, s_tlast, m_tready;
  logic [15:0] s_tdata;

  logic        s_tready_a, m_tvalid_a, m_tlast_a;
  logic [7:0]  m_tdata_a;
  logic        s_tready_b, m_tvalid_b, m_tlast_b;
  logic [7:0]  m_tdata_b;
  logic        s_tready_c, m_tvalid_c, m_tlast_c;
  logic [15:0] m_tdata_c;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  axis_parity_checker #(.DATA_WIDTH(8), .ODD_PARITY(1'b0)) u_a (
    .in_clock(clk), .in_reset(rst),
    .axis_s_tvalid(s_tvalid), .axis_s_tdata(s_tdata[7:0]), .axis_s_tready(s_tready_a),
    .axis_s_tlast(s_tlast), .axis_m_tvalid(m_tvalid_a), .axis_m_tdata(m_tdata_a),
    .axis_m_tready(m_tready), .axis_m_tlast(m_tlast_a));

  axis_parity_checker #(.DATA_WIDTH(8), .ODD_PARITY(1'b1)) u_b (
    .in_clock(clk), .in_reset(rst),
    .axis_s_tvalid(s_tvalid), .axis_s_tdata(s_tdata[7:0]), .axis_s_tready(s_tready_b),
    .axis_s_tlast(s_tlast), .axis_m_tvalid(m_tvalid_b), .axis_m_tdata(m_tdata_b),
    .axis_m_tready(m_tready), .axis_m_tlast(m_tlast_b));

  axis_parity_checker #(.DATA_WIDTH(16), .ODD_PARITY(1'b1)) u_c (
    .in_clock(clk), .in_reset(rst),
    .axis_s_tvalid(s_tvalid), .axis_s_tdata(s_tdata), .axis_s_tready(s_tready_c),
    .axis_s_tlast(s_tlast), .axis_m_tvalid(m_tvalid_c), .axis_m_tdata(m_tdata_c),
    .axis_m_tready(m_tready), .axis_m_tlast(m_tlast_c));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Present one beat and hold it until accepted (ready sampled before the edge).
  task automatic send(input logic [15:0] d, input logic l);
    logic ok;
    int   n;
    s_tvalid = 1'b1; s_tdata = d; s_tlast = l;
    ok = 1'b0; n = 0;
    while (!ok && n < 50) begin
      @(negedge clk); ok = s_tready_a;
      @(posedge clk); #1; n++;
    end
    if (!ok) check("send_timeout", 64'(ok), 64'd1);
    s_tvalid = 1'b0; s_tlast = 1'b0;
  endtask

  initial begin
    rst = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0; m_tready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_m_tvalid", 64'(m_tvalid_a), 64'd0);
    check("rst_m_tlast",  64'(m_tlast_a),  64'd0);
    check("rst_m_tdata",  64'(m_tdata_a),  64'h0);
    check("rst_s_tready", 64'(s_tready_a), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_rel_s_tready", 64'(s_tready_a), 64'd1);

    // Multi-beat packet with parity error
    send(16'h01, 1'b0);
    send(16'h03, 1'b1);
    check("t1_m_tvalid", 64'(m_tvalid_a), 64'd1);
    check("t1_m_tlast",  64'(m_tlast_a),  64'd1);
    check("t1_m_tdata",  64'(m_tdata_a),  64'h0B);
    check("t1_s_tready", 64'(s_tready_a), 64'd0);
    @(posedge clk); #1;
    check("t1_s_tready_next", 64'(s_tready_a), 64'd1);
    check("t1_m_tvalid_next", 64'(m_tvalid_a), 64'd0);

    // Single-beat packet, even and odd expectation
    send(16'hFF, 1'b1);
    check("t2_even_tdata", 64'(m_tdata_a), 64'h04);
    check("t2_odd_tdata",  64'(m_tdata_b), 64'h06);

    // Count saturation, then cleared state
    for (int i = 0; i < 69; i++) send(16'h00, 1'b0);
    send(16'h00, 1'b1);
    check("t3_sat_tdata", 64'(m_tdata_a), 64'hFC);
    send(16'h80, 1'b1);
    check("t3_clear_tdata", 64'(m_tdata_a), 64'h07);

    // Backpressure on the result
    @(posedge clk); #1;
    m_tready = 1'b0;
    send(16'h07, 1'b1);
    s_tvalid = 1'b1; s_tdata = 16'h55; s_tlast = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_hold_tvalid", 64'(m_tvalid_a), 64'd1);
      check("t4_hold_tlast",  64'(m_tlast_a),  64'd1);
      check("t4_hold_tdata",  64'(m_tdata_a),  64'h07);
      check("t4_hold_sready", 64'(s_tready_a), 64'd0);
    end
    m_tready = 1'b1;
    @(posedge clk); #1;
    check("t4_drain_tvalid", 64'(m_tvalid_a), 64'd0);
    check("t4_drain_sready", 64'(s_tready_a), 64'd1);
    @(posedge clk); #1;
    s_tvalid = 1'b0; s_tlast = 1'b0;
    check("t4_next_tvalid", 64'(m_tvalid_a), 64'd1);
    check("t4_next_tdata",  64'(m_tdata_a),  64'h04);
    @(posedge clk); #1;

    // Reset mid-packet
    send(16'h01, 1'b0);
    send(16'h02, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("t5a_tvalid",  64'(m_tvalid_a), 64'd0);
    check("t5a_tdata",   64'(m_tdata_a),  64'h0);
    check("t5a_sready",  64'(s_tready_a), 64'd0);
    @(posedge clk); #1;
    check("t5a_tvalid2", 64'(m_tvalid_a), 64'd0);
    check("t5a_sready2", 64'(s_tready_a), 64'd1);
    send(16'h03, 1'b1);
    check("t5a_tdata_after", 64'(m_tdata_a), 64'h04);
    @(posedge clk); #1;

    // Reset while a result is pending, even with sink ready
    m_tready = 1'b0;
    send(16'h01, 1'b1);
    check("t5b_pending", 64'(m_tvalid_a), 64'd1);
    rst = 1'b1; m_tready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("t5b_tvalid", 64'(m_tvalid_a), 64'd0);
    check("t5b_tlast",  64'(m_tlast_a),  64'd0);
    @(posedge clk); #1;

    // Wide configuration; narrow instances see the low byte
    send(16'h8001, 1'b0);
    send(16'h0001, 1'b1);
    check("t6_wide_tdata", 64'(m_tdata_c), 64'h0009);
    check("t6_wide_tlast", 64'(m_tlast_c), 64'd1);
    check("t6_narrow_even", 64'(m_tdata_a), 64'h08);
    check("t6_narrow_odd",  64'(m_tdata_b), 64'h0A);
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
